gpio_input_conditioner: RTL
===========================

Name: gpio_input_conditioner

Overview:
- Sits between the raw GPIO input pads and the GPIO controller's 12-bit `gpio_in` port.
- Per pin: synchronises the asynchronous pin to `clk`, debounces it with a prescaled stability counter, and emits one-cycle rise/fall pulses.
- Latches edge events into sticky pending bits and drives a single level interrupt `irq`.
- Gives the controller clean, glitch-free, metastability-safe levels plus event information.

Parameters:
- WIDTH, 12, number of input pins; must match the controller's `gpio_in` width.
- PRESCALE, 1000, `clk` cycles per sample tick; 1 means a tick every cycle; must be ≥1.
- DEBOUNCE_TICKS, 8, consecutive ticks a new level must hold before it is accepted; must be ≥1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- pin_raw  input  WIDTH  asynchronous pad inputs
- pin_stable  output  WIDTH  debounced levels; feeds the controller's `gpio_in`
- rise_pulse  output  WIDTH  one-cycle pulse when `pin_stable[i]` goes 0→1
- fall_pulse  output  WIDTH  one-cycle pulse when `pin_stable[i]` goes 1→0
- event_en  input  WIDTH  per-pin enable for latching events into pending
- event_clear  input  WIDTH  per-pin write-1-to-clear of pending, single-cycle strobe
- event_pending  output  WIDTH  sticky per-pin event flags
- irq  output  1  OR of `event_pending`

Behaviour:
- **Reset** (`rst`=1 at a `clk` edge): all of the following clear to 0.
  - Sync flops, prescaler, debounce counters.
  - `pin_stable`, `rise_pulse`, `fall_pulse`, `event_pending`, `irq`.
- **Reset mid-count:** discards any partial debounce; `pin_stable` returns to 0 regardless of `pin_raw`.
- **Synchroniser:** two flops per pin, `sync1` then `sync2`. Only `sync2` is used downstream.
- **Prescaler:**
  - Counter 0..PRESCALE-1, wraps to 0.
  - `tick`=1 in the cycle the counter equals PRESCALE-1. With PRESCALE=1, `tick` is constantly 1.
  - Counter width is clog2(PRESCALE), minimum 1 bit.
- **Debounce, per pin, evaluated only on `tick`:**
  - If `sync2` == `pin_stable`: count <= 0.
  - Else if count == DEBOUNCE_TICKS-1: `pin_stable` <= `sync2`, count <= 0.
  - Else: count <= count+1.
  - Counter width is clog2(DEBOUNCE_TICKS), minimum 1 bit; it never exceeds DEBOUNCE_TICKS-1, so there is no overflow.
  - On non-tick cycles, count and `pin_stable` hold.
- **Latency** (PRESCALE=1): a clean `pin_raw` step appears on `pin_stable` at the (DEBOUNCE_TICKS+2)th rising edge after the step.
- **Glitch rejection:** any return of `sync2` to the `pin_stable` value before acceptance resets the count. A glitch shorter than DEBOUNCE_TICKS ticks never reaches `pin_stable`.
- **Edge pulses:**
  - Registered in the same edge that `pin_stable` changes, so they are coincident with the new level.
  - Exactly one cycle wide; low at all other times.
- **Pending, per pin, at each edge:**
  - set = (`rise_pulse` | `fall_pulse`) & `event_en`.
  - `event_pending` <= set | (`event_pending` & ~`event_clear`).
  - Simultaneous set and clear: set wins.
- **irq:** combinational OR of the registered `event_pending`; no extra latency.
- **Pin independence:** pins are fully independent. Multiple pins may change, pulse and pend in the same cycle.

Decomposition:
- Shared package `gpio_pkg`:
  - GPIO_IN_WIDTH=12 and GPIO_OUT_WIDTH=18 constants.
  - Default PRESCALE and DEBOUNCE_TICKS constants.
  - Used by both this block and the controller.
- Sub-module `gpio_debounce_cell`:
  - One pin: synchroniser, counter, stable flop, pulse flops.
  - Inputs: `clk`, `rst`, `tick`, `raw`.
  - Instantiated WIDTH times in a generate loop.
- The prescaler and the pending/irq logic stay in the top level.

Test Plan:
- **Reset:** hold `rst`=1 for 3 cycles with `pin_raw`=12'hFFF → all outputs 0. After release, `pin_stable` = 12'hFFF at the 10th edge (PRESCALE=1, DEBOUNCE_TICKS=8).
- **Clean rise:** PRESCALE=1, DEBOUNCE_TICKS=4; `pin_raw[3]` 0→1 and held → `pin_stable[3]`=1 and `rise_pulse[3]`=1 after the 6th edge. Pulse low after the 7th edge; `fall_pulse` stays 0.
- **Glitch:** `pin_raw[0]`=1 for 3 cycles, then 0, with DEBOUNCE_TICKS=4 → `pin_stable[0]`, `rise_pulse` and `fall_pulse` never assert.
- **Prescaler:** PRESCALE=5, DEBOUNCE_TICKS=2; step on `pin_raw[11]` → `pin_stable[11]` changes only on a tick edge. The change lands 6–10 edges after `sync2` flips; no change occurs on non-tick edges.
- **Events:** `event_en`=12'h001; pin0 falls → `event_pending`=12'h001 and `irq`=1. Pulse `event_clear[0]` in the same cycle as a second `fall_pulse[0]` → pending stays 1. A later clear alone → pending 0, `irq` 0.
- **Reset mid-count:** assert `rst` while pin5's count=2 → count 0 and `pin_stable` 0. With `pin_raw[5]` still 1, a full DEBOUNCE_TICKS+2 edges must elapse after release before `pin_stable[5]`=1.

Source files
------------

// File: rtl/gpio_pkg.sv
// Constants shared by the GPIO controller and its input conditioner.
package gpio_pkg;

  localparam int GPIO_IN_WIDTH          = 12;
  localparam int GPIO_OUT_WIDTH         = 18;
  localparam int DEFAULT_PRESCALE       = 1000;
  localparam int DEFAULT_DEBOUNCE_TICKS = 8;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_debounce_cell.sv
// One pin: two-flop synchroniser, tick-driven stability counter, debounced
// level and single-cycle edge pulses coincident with the level change.
module gpio_debounce_cell
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int             CW       = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (tick) begin
      // Any return to the accepted level restarts the stability window.
      if (sync2_q == stable_q) begin
        cnt_d = {CW{1'b0}};
      end else if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = {CW{1'b0}};
        rise_d   = sync2_q;
        fall_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Synchronises and debounces the raw GPIO pads, reports edges and latches
// enabled edge events into sticky pending flags that drive a level irq.
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH          = GPIO_IN_WIDTH,
  parameter int PRESCALE       = DEFAULT_PRESCALE,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_raw,
  output logic [WIDTH-1:0] pin_stable,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  input  logic [WIDTH-1:0] event_en,
  input  logic [WIDTH-1:0] event_clear,
  output logic [WIDTH-1:0] event_pending,
  output logic             irq
);

  localparam int             PCW      = cnt_width(PRESCALE);
  localparam logic [PCW-1:0] PRE_LAST = PCW'(PRESCALE - 1);

  logic [PCW-1:0]   pre_q, pre_d;
  logic             tick_s;
  logic [WIDTH-1:0] pending_q, pending_d;

  // With PRESCALE=1 the counter sits at zero and tick is permanently high.
  assign tick_s = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q;
    if (tick_s) begin
      pre_d = {PCW{1'b0}};
    end else begin
      pre_d = pre_q + PCW'(1);
    end
  end

  // A new event in the same cycle as its clear strobe must not be lost.
  always_comb begin
    pending_d = ((rise_pulse | fall_pulse) & event_en) | (pending_q & ~event_clear);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= {PCW{1'b0}};
      pending_q <= {WIDTH{1'b0}};
    end else begin
      pre_q     <= pre_d;
      pending_q <= pending_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce_cell #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick_s),
      .raw   (pin_raw[i]),
      .stable(pin_stable[i]),
      .rise  (rise_pulse[i]),
      .fall  (fall_pulse[i])
    );
  end

  assign event_pending = pending_q;
  assign irq           = |pending_q;

endmodule
